// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the LCD write arbiter: FSM encoding, LCD byte layout
// and the default settle delay used by lcd_messages-style writers.
package lcd_arb_pkg;

  localparam int LCD_W = 9;

  localparam logic [17:0] DLY_DEFAULT = 18'h3FFFE;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DLY   = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  // One requester slice of iWDATA: {RS, DATA[7:0]}.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at or
// after ptr, wrapping past the top requester.
module rr_pick
  import lcd_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   index,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [PTR_W:0]     off;
  logic [PTR_W:0]     sum;

  always_comb begin
    // Rotate so that bit 0 of rot is requester ptr; the lowest set bit wins.
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (PTR_W+1)'(i);
    end
    sum = off + {1'b0, ptr};
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    index = sum[PTR_W-1:0];
    any   = |req;
    grant = any ? (NUM_REQ'(1) << index) : '0;
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares one lcd_controller byte-write port between NUM_REQ requesters with
// round-robin grant per burst, owning the start/done handshake and settle delay.
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int               NUM_REQ    = 3,
  parameter int               DLY_W      = 18,
  parameter logic [DLY_W-1:0] DLY_CYCLES = DLY_W'(DLY_DEFAULT)
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [NUM_REQ-1:0]       iREQ,
  input  logic [LCD_W*NUM_REQ-1:0] iWDATA,
  input  logic [NUM_REQ-1:0]       iLAST,
  output logic [NUM_REQ-1:0]       oGRANT,
  output logic [NUM_REQ-1:0]       oACK,
  output logic                     oBUSY,
  output logic [7:0]               oLCD_DATA,
  output logic                     oLCD_RS,
  output logic                     oLCD_START,
  input  logic                     iLCD_DONE
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester handshake: iREQ[k] is a level "byte valid" held with its
  // iWDATA/iLAST slice until oACK[k] pulses for one cycle ("byte consumed").
  // A grantee wishing to continue its burst must present the next byte with
  // iREQ still high by the cycle after that ack; otherwise the burst ends.

  logic [2:0]         state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win_q;
  logic [DLY_W-1:0]   cnt_q;
  logic               last_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  lcd_byte_t          pick_byte;
  lcd_byte_t          win_byte;
  logic [PTR_W-1:0]   ptr_after;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (iREQ),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  assign pick_byte = lcd_byte_t'(iWDATA[LCD_W*pick_idx +: LCD_W]);
  assign win_byte  = lcd_byte_t'(iWDATA[LCD_W*win_q +: LCD_W]);

  // Priority passes to the requester after the one whose burst just ended.
  assign ptr_after = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

  assign oACK  = (state_q == ST_ACK) ? oGRANT : '0;
  assign oBUSY = (state_q != ST_IDLE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      oGRANT     <= '0;
      oLCD_DATA  <= '0;
      oLCD_RS    <= 1'b0;
      oLCD_START <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            oGRANT     <= pick_grant;
            win_q      <= pick_idx;
            oLCD_RS    <= pick_byte.rs;
            oLCD_DATA  <= pick_byte.data;
            last_q     <= iLAST[pick_idx];
            oLCD_START <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (iLCD_DONE) begin
            oLCD_START <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_DLY;
          end
        end
        ST_DLY: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == DLY_CYCLES - 1'b1) state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (last_q) begin
            oGRANT  <= '0;
            ptr_q   <= ptr_after;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (iREQ[win_q]) begin
            oLCD_RS    <= win_byte.rs;
            oLCD_DATA  <= win_byte.data;
            last_q     <= iLAST[win_q];
            oLCD_START <= 1'b1;
            state_q    <= ST_START;
          end else begin
            // Grantee let go mid-burst: release the port without another write.
            oGRANT  <= '0;
            ptr_q   <= ptr_after;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized scoreboard bench for lcd_write_arbiter with a behavioural
// lcd_controller and a burst-level round-robin reference model.
module tb_lcd_write_arbiter;
  import lcd_arb_pkg::*;

  localparam int N   = 3;
  localparam int DLY = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     last = '0;
  logic [9*N-1:0]   wdata = '0;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic             busy;
  logic [7:0]       lcd_data;
  logic             lcd_rs;
  logic             lcd_start;
  logic             lcd_done = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Expected LCD writes {grant, rs, data} and expected acks, in order.
  logic [11:0]  exp_q[$];
  logic [N-1:0] exp_ack_q[$];

  // Requester job entries: {drop_req_after_ack, last, rs, data}.
  logic [10:0] jq[N][$];
  logic [10:0] pend[N][$];
  int          ptr_m = 0;

  int stray_req    = 0;
  bit stray_dly_en = 1'b0;

  lcd_write_arbiter #(
    .NUM_REQ    (N),
    .DLY_W      (18),
    .DLY_CYCLES (18'd4)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iREQ       (req),
    .iWDATA     (wdata),
    .iLAST      (last),
    .oGRANT     (grant),
    .oACK       (ack),
    .oBUSY      (busy),
    .oLCD_DATA  (lcd_data),
    .oLCD_RS    (lcd_rs),
    .oLCD_START (lcd_start),
    .iLCD_DONE  (lcd_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ---------------- lcd_controller model ----------------
  initial begin : lcd_model
    int  cd;
    int  stray_cd;
    int  stray_ack;
    bit  seen;
    cd = 0; stray_cd = 0; stray_ack = 0; seen = 1'b0;
    forever begin
      @(posedge clk); #1;
      lcd_done = 1'b0;
      if (rst) begin
        cd = 0; stray_cd = 0; seen = 1'b0;
      end else begin
        if (stray_cd > 0) begin
          stray_cd--;
          if (stray_cd == 0) lcd_done = 1'b1;
        end
        if (lcd_start && !seen) begin
          seen = 1'b1;
          cd   = 3;
        end
        if (!lcd_start) seen = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            lcd_done = 1'b1;
            if (stray_dly_en) stray_cd = 2;
          end
        end
        if (stray_req != stray_ack) begin
          stray_ack = stray_req;
          lcd_done  = 1'b1;
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  initial begin : driver
    int          cool[N];
    int          wt[N];
    bit          active[N];
    logic [10:0] e;
    for (int k = 0; k < N; k++) begin
      cool[k] = 0; wt[k] = 0; active[k] = 1'b0;
    end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (cool[k] > 0) begin
          cool[k]--;
        end else if (active[k]) begin
          if (ack[k] && jq[k].size() > 0) begin
            e = jq[k].pop_front();
            wt[k] = 0;
            if (e[10] || jq[k].size() == 0) begin
              req[k]    = 1'b0;
              active[k] = 1'b0;
              cool[k]   = 2;
            end else begin
              wdata[9*k +: 9] = jq[k][0][8:0];
              last[k]         = jq[k][0][9];
            end
          end else begin
            wt[k]++;
            if (wt[k] > 400) begin
              n_cmp++; n_fail++;
              $display("FAIL ack_timeout: requester %0d got no ack within 400 cycles", k);
              jq[k].delete();
              req[k]    = 1'b0;
              active[k] = 1'b0;
            end
          end
        end else if (jq[k].size() > 0) begin
          wdata[9*k +: 9] = jq[k][0][8:0];
          last[k]         = jq[k][0][9];
          req[k]          = 1'b1;
          active[k]       = 1'b1;
          wt[k]           = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_start = 1'b0;
  int          done_cyc   = -100;
  logic [11:0] exp_w;
  logic [N-1:0] exp_a;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 1'b0;
        continue;
      end
      if (lcd_done && lcd_start) done_cyc = cyc;
      if (lcd_start && !prev_start) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_start: grant=%b rs=%b data=%h expected no write", grant, lcd_rs, lcd_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("lcd_write", {20'd0, grant, lcd_rs, lcd_data}, {20'd0, exp_w});
        end
      end
      prev_start = lcd_start;
      if (ack != '0) begin
        if (exp_ack_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          exp_a = exp_ack_q.pop_front();
          check("ack_owner", 32'(ack), 32'(exp_a));
          check("ack_latency", 32'(cyc - done_cyc), 32'(DLY + 1));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic add_burst(input int k, input int n, input bit abandon);
    logic [8:0] v;
    bit         fin;
    for (int b = 0; b < n; b++) begin
      v   = 9'($urandom);
      fin = (b == n - 1);
      pend[k].push_back({fin, fin && !abandon, v});
    end
  endtask

  // Whole bursts are granted in round-robin order among requesters with work
  // pending; every requester in a phase raises its request at the same time.
  task automatic launch();
    int          k;
    bit          found;
    logic [10:0] e;
    for (int r = 0; r < N; r++)
      for (int i = 0; i < pend[r].size(); i++) jq[r].push_back(pend[r][i]);
    while (1) begin
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < N; i++) begin
        k = (ptr_m + i) % N;
        if (pend[k].size() > 0) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) break;
      do begin
        e = pend[k].pop_front();
        exp_q.push_back({N'(1 << k), e[8:0]});
        exp_ack_q.push_back(N'(1 << k));
      end while (!e[10]);
      ptr_m = (k + 1) % N;
    end
  endtask

  function automatic bit all_done();
    bit d;
    d = (exp_q.size() == 0) && (exp_ack_q.size() == 0) && !busy;
    for (int k = 0; k < N; k++) if (jq[k].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!all_done() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: writes left %0d acks left %0d busy %b", name, exp_q.size(), exp_ack_q.size(), busy);
      exp_q.delete();
      exp_ack_q.delete();
    end
    repeat (5) @(negedge clk);
    check({name, "_grant_idle"}, 32'(grant), 32'd0);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(lcd_start), 32'd0);
    check("rst_rs_data", {23'd0, lcd_rs, lcd_data}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset mid-settle abandons the byte; the held request is then re-granted.
    jq[0].push_back({1'b1, 1'b1, 1'b1, 8'h50});
    exp_q.push_back({3'b001, 1'b1, 8'h50});
    exp_q.push_back({3'b001, 1'b1, 8'h50});
    exp_ack_q.push_back(3'b001);
    for (int t = 0; t < 50 && !lcd_start; t++) @(negedge clk);
    check("rsttest_start_high", 32'(lcd_start), 32'd1);
    for (int t = 0; t < 50 && lcd_start; t++) @(negedge clk);
    check("rsttest_start_low", 32'(lcd_start), 32'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_start", 32'(lcd_start), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_regrant", 32'(grant), 32'b001);
    ptr_m = 1;
    wait_idle("single");

    // Priority now starts at requester 1.
    add_burst(1, 1, 1'b0);
    add_burst(2, 1, 1'b0);
    launch();
    wait_idle("ptr1");

    // Round robin over all three, two single-byte bursts each.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) add_burst(k, 1, 1'b0);
    launch();
    wait_idle("rr");

    // Burst lock: 16 bytes from req0 while req1 waits; stray DONEs in DLY.
    stray_dly_en = 1'b1;
    add_burst(0, 16, 1'b0);
    add_burst(1, 1, 1'b0);
    launch();
    wait_idle("lock");
    stray_dly_en = 1'b0;

    // Abandon: req2 drops its request after the ack of byte 2 (LAST=0).
    add_burst(2, 2, 1'b1);
    launch();
    wait_idle("abandon");
    for (int k = 0; k < N; k++) add_burst(k, 1, 1'b0);
    launch();
    wait_idle("after_abandon");

    // Stray DONE while idle must not start anything.
    stray_req++;
    repeat (6) @(negedge clk);
    check("stray_idle_busy", 32'(busy), 32'd0);
    check("stray_idle_start", 32'(lcd_start), 32'd0);

    // Random phases.
    for (int p = 0; p < 8; p++) begin
      stray_dly_en = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) begin
        int nb;
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++)
          add_burst(k, $urandom_range(1, 4), $urandom_range(0, 4) == 0);
      end
      launch();
      wait_idle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
